fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the main decoder.
- Owns the program counter and fetches instructions over a req/ack instruction-memory port.
- Presents the held instruction and its pc/pc+4 to decode, then computes the next PC when the instruction retires, using the decoder's branch/jump controls and the ALU zero flag.
- Inserts wait states for slow memory and reports misaligned targets and fetch timeouts.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- MAX_WAIT, 15, maximum cycles FETCH waits for imem_ack before faulting (1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always equals the PC register.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; decode takes op from instr[6:0].
- instr_pc  out  32  PC of the held instruction.
- instr_pcplus4  out  32  instr_pc + 4, for jal/jalr writeback.
- instr_valid  out  1  instr is valid for decode/execute.
- retire  in  1  execute finishes the held instruction this cycle.
- branch  in  1  decoder branch control.
- zero  in  1  ALU zero flag.
- jump  in  1  decoder jump control.
- jalr  in  1  held instruction is jalr (op 1100111).
- pctarget  in  32  pc + immediate from the target adder.
- aluresult  in  32  rs1 + imm, used for the jalr target.
- fetch_fault  out  1  sticky fault flag.

Behaviour:
- Interface: one clock, clk. rst is asynchronous, active-high.
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr=0 (op 0000000 decodes to all-zero controls), instr_pc=0, instr_pcplus4=0, instr_valid=0, fetch_fault=0, wait counter=0.
- States: IDLE, FETCH, HOLD, FAULT.
- IDLE: entered on reset; moves to FETCH on the first clock edge after rst deasserts; imem_req=0.
- FETCH:
  - imem_req=1.
  - imem_ack is sampled each edge; same-cycle ack is legal.
  - On ack: instr<=imem_rdata, instr_pc<=pc, instr_pcplus4<=pc+4, instr_valid<=1, go to HOLD. instr_valid rises the cycle after the ack.
  - No ack: wait counter increments. When the counter reaches MAX_WAIT without an ack, go to FAULT.
  - The wait counter clears on leaving FETCH.
- HOLD:
  - imem_req=0; instr/instr_pc stable; instr_valid=1.
  - Stays in HOLD while retire=0.
  - On retire: compute next PC, go to FETCH with instr_valid<=0 on the same edge. imem_req rises the cycle after retire.
- Next-PC rules, evaluated on retire:
  - pcsrc = (branch & zero) | jump.
  - jump & jalr: next = {aluresult[31:1],1'b0}.
  - Otherwise, if pcsrc: next = pctarget.
  - Otherwise: next = pc+4, mod 2^32 (0xFFFFFFFC wraps to 0).
- Misaligned target: if next[1]=1, pc is not updated, fetch_fault<=1, go to FAULT.
- FAULT: imem_req=0, instr_valid=0, fetch_fault=1. Exited only by rst.
- imem_ack outside FETCH is ignored. Covers acks in IDLE, HOLD and FAULT, and a late ack after reset aborted a fetch.
- retire outside HOLD is ignored.
- Reset mid-fetch or mid-hold: all state returns to reset values immediately (asynchronous); the pending transfer is abandoned.
- branch/zero/jump/jalr/pctarget/aluresult are sampled only on the retire edge.

Test Plan:
- Reset release, ack returned the same cycle as each req with rdata 0x00500093, retire pulsed whenever instr_valid is high -> first imem_addr=0x0; instr=0x00500093, instr_pc=0, instr_pcplus4=4; next fetch at 0x4; sequential fetches 0,4,8.
- Taken branch, then not-taken branch: instr_pc=0x10, branch=1, zero=1, pctarget=0x40, retire -> next imem_addr=0x40; repeat with zero=0 -> 0x14.
- jalr: jump=1, jalr=1, aluresult=0x101 -> fetch at 0x100. Same with aluresult=0x102 -> fetch_fault=1, imem_req stays 0, pc unchanged.
- Slow memory with MAX_WAIT=3: ack after 2 wait cycles -> instr_valid one cycle later. No ack -> FAULT after exactly 3 waiting cycles. Stray ack while in HOLD -> instr unchanged.
- Wrap-around and mid-fetch reset: pc=0xFFFFFFFC with sequential retire -> next fetch at 0x0. rst asserted mid-FETCH -> imem_req drops asynchronously; a late ack is ignored; refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the main decoder.
//
// Owns the program counter and fetches one instruction at a time over a
// req/ack memory port. The instruction is held for decode/execute until it
// retires. The next PC is then taken from the branch/jump controls and the
// ALU zero flag. Slow memory is tolerated up to MAX_WAIT cycles. A timeout or
// a misaligned next PC parks the unit in FAULT until reset.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   imem_req/imem_addr    fetch request and address (address is the PC)
//   imem_ack/imem_rdata   memory response, accepted only while fetching
//   instr, instr_pc,      held instruction, its PC and PC+4
//   instr_pcplus4
//   instr_valid           held instruction is valid for decode/execute
//   retire                execute finishes the held instruction
//   branch, zero, jump,   next-PC controls, sampled on the retire edge
//   jalr, pctarget,
//   aluresult
//   fetch_fault           sticky fault flag
//
// state | meaning
// IDLE  | just out of reset; starts fetching on the next edge
// FETCH | request outstanding, counting wait cycles
// HOLD  | instruction held for decode/execute until retire
// FAULT | timeout or misaligned target; left only through reset

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jalr,
  input  logic [31:0] pctarget,
  input  logic [31:0] aluresult,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

  // The timeout fires on the edge that would take the counter to MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic [31:0] next_pc;

  assign imem_addr = pc;

  // jalr clears bit 0 of the computed target. Bit 1 is left alone, so the
  // misalignment check below can still catch it.
  always_comb begin
    next_pc = pc + 32'd4;
    if (jump && jalr)
      next_pc = aluresult & ~32'd1;
    else if ((branch && zero) || jump)
      next_pc = pctarget;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      wait_cnt      <= 8'd0;
      imem_req      <= 1'b0;
      instr         <= 32'd0;
      instr_pc      <= 32'd0;
      instr_pcplus4 <= 32'd0;
      instr_valid   <= 1'b0;
      fetch_fault   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr         <= imem_rdata;
            instr_pc      <= pc;
            instr_pcplus4 <= pc + 32'd4;
            instr_valid   <= 1'b1;
            imem_req      <= 1'b0;
            wait_cnt      <= 8'd0;
            state         <= HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            wait_cnt    <= 8'd0;
            state       <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (retire) begin
            instr_valid <= 1'b0;
            if (next_pc[1]) begin
              // The PC keeps the faulting instruction's address.
              fetch_fault <= 1'b1;
              state       <= FAULT;
            end else begin
              pc       <= next_pc;
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        FAULT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule
